reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Ordered reset release for up to NUM_STAGES clock domains, gated on PLL lock,
// a per-stage minimum gap and optional per-stage readiness acknowledges.
module reset_sequencer #(
   parameter int                    NUM_STAGES   = 4,
   parameter int                    HOLD_CYCLES  = 16,
   parameter int                    STAGE_GAP    = 8,
   parameter int                    LOCK_TIMEOUT = 65535,
   parameter logic [NUM_STAGES-1:0] ACK_MASK     = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  seq_done,
   output logic                  lock_timeout_err,
   output logic [2:0]            state
);

   localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int CNT_MAX_A = (LOCK_TIMEOUT > HOLD_CYCLES) ? LOCK_TIMEOUT : HOLD_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > STAGE_GAP) ? CNT_MAX_A : STAGE_GAP;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      RESET_ALL = 3'd0,
      WAIT_LOCK = 3'd1,
      HOLD      = 3'd2,
      RELEASE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_STAGES-1:0]   rst_stage_q, rst_stage_d;
   logic                    seq_done_q, seq_done_d;
   logic                    err_q, err_d;

   logic                    lock_meta_q, lock_sync_q;
   logic [NUM_STAGES-1:0]   ack_meta_q, ack_sync_q;

   logic [IDX_W-1:0]        idx_inc;
   logic [NUM_STAGES-1:0]   cur_sel;
   logic [NUM_STAGES-1:0]   next_sel;
   logic                    ack_ok;
   logic                    lock_lost;

   assign idx_inc = idx_q + IDX_W'(1);

   // One-hot decodes keep stage selection in range for non-power-of-2 counts.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
         assign cur_sel[gi]  = (idx_q == IDX_W'(gi));
         assign next_sel[gi] = (idx_inc == IDX_W'(gi));
      end
   endgenerate

   assign ack_ok    = |(cur_sel & (ack_sync_q | ~ACK_MASK));
   assign lock_lost = !lock_sync_q &&
                      (state_q == HOLD || state_q == RELEASE || state_q == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         ack_meta_q  <= '0;
         ack_sync_q  <= '0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_sync_q <= lock_meta_q;
         ack_meta_q  <= stage_ack;
         ack_sync_q  <= ack_meta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      rst_stage_d = rst_stage_q;
      seq_done_d  = seq_done_q;
      err_d       = err_q;

      unique case (state_q)
         RESET_ALL: begin
            rst_stage_d = '1;
            seq_done_d  = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
            state_d     = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_sync_q) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else if (cnt_q != TIMEOUT_VAL) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == TIMEOUT_VAL) begin
                  err_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d        = RELEASE;
               idx_d          = '0;
               cnt_d          = '0;
               rst_stage_d[0] = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            // Gap counter parks on its last value until the current stage is ready.
            if (cnt_q == GAP_LAST) begin
               if (ack_ok) begin
                  if (idx_q == IDX_LAST) begin
                     state_d    = DONE;
                     seq_done_d = 1'b1;
                  end else begin
                     idx_d       = idx_inc;
                     cnt_d       = '0;
                     rst_stage_d = rst_stage_q & ~next_sel;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = RESET_ALL;
         end
      endcase

      if (lock_lost || sw_rst_req) begin
         state_d     = RESET_ALL;
         rst_stage_d = '1;
         seq_done_d  = 1'b0;
         cnt_d       = '0;
         idx_d       = '0;
      end
      if (sw_rst_req) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RESET_ALL;
         idx_q       <= '0;
         cnt_q       <= '0;
         rst_stage_q <= '1;
         seq_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         rst_stage_q <= rst_stage_d;
         seq_done_q  <= seq_done_d;
         err_q       <= err_d;
      end
   end

   assign rst_stage        = rst_stage_q;
   assign seq_done         = seq_done_q;
   assign lock_timeout_err = err_q;
   assign state            = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random lock/request/ack
// traffic, every cycle compared against an event-time reference model.
module tb_reset_sequencer;

   localparam int N   = 4;
   localparam int HC  = 16;
   localparam int GAP = 8;
   localparam int LT  = 100;
   localparam logic [N-1:0] MASK = 4'b0100;

   localparam logic [2:0] S_RESET = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_HOLD  = 3'd2;
   localparam logic [2:0] S_REL   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pll_locked;
   logic         sw_rst_req;
   logic [N-1:0] stage_ack;
   logic [N-1:0] rst_stage;
   logic         seq_done;
   logic         lock_timeout_err;
   logic [2:0]   state;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES  (N),
      .HOLD_CYCLES (HC),
      .STAGE_GAP   (GAP),
      .LOCK_TIMEOUT(LT),
      .ACK_MASK    (MASK)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .sw_rst_req      (sw_rst_req),
      .stage_ack       (stage_ack),
      .rst_stage       (rst_stage),
      .seq_done        (seq_done),
      .lock_timeout_err(lock_timeout_err),
      .state           (state)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: phase plus the edge numbers of phase entry and of the
   // most recent release; outputs follow from the count of released stages.
   int           m_phase;
   int           m_t0;
   int           m_rel;
   int           m_trel;
   bit           m_err;
   bit           lk1, lk2;
   logic [N-1:0] ak1, ak2;
   logic [N-1:0] mask_v = MASK;
   logic [N-1:0] ones_v = '1;
   logic [N-1:0] prev_stage;
   int           chg_q[$];

   task automatic model_step();
      bit           lock_s;
      logic [N-1:0] ack_s;
      lock_s = lk2;
      ack_s  = ak2;
      lk2 = lk1;
      lk1 = pll_locked;
      ak2 = ak1;
      ak1 = stage_ack;
      if (!rst_n) begin
         m_phase = 0; m_rel = 0; m_err = 0;
         lk1 = 0; lk2 = 0; ak1 = '0; ak2 = '0;
      end else if (sw_rst_req) begin
         m_phase = 0; m_rel = 0; m_err = 0;
      end else if (m_phase >= 2 && !lock_s) begin
         m_phase = 0; m_rel = 0;
      end else begin
         case (m_phase)
            0: begin
               m_phase = 1;
               m_t0    = cyc;
            end
            1: begin
               if (lock_s) begin
                  m_phase = 2;
                  m_t0    = cyc;
               end else if (cyc - m_t0 >= LT) begin
                  m_err = 1;
               end
            end
            2: begin
               if (cyc - m_t0 == HC) begin
                  m_phase = 3;
                  m_rel   = 1;
                  m_trel  = cyc;
               end
            end
            3: begin
               if (cyc - m_trel >= GAP && (ack_s[m_rel-1] || !mask_v[m_rel-1])) begin
                  if (m_rel == N) begin
                     m_phase = 4;
                  end else begin
                     m_rel++;
                     m_trel = cyc;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      logic [N-1:0] exp_stage;
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      exp_stage = ones_v << m_rel;
      check_val("rst_stage", 32'(rst_stage), 32'(exp_stage));
      check_val("seq_done", 32'(seq_done), 32'(m_phase == 4));
      check_val("timeout_err", 32'(lock_timeout_err), 32'(m_err));
      check_val("state", 32'(state), 32'(m_phase));
      if (rst_stage !== prev_stage) chg_q.push_back(cyc);
      prev_stage = rst_stage;
      stage_ack = (stage_ack & mask_v) | (N'($urandom) & ~mask_v);
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
      int k = 0;
      while (state !== st && k < budget) begin
         tick();
         k++;
      end
      check_val(tag, 32'(state), 32'(st));
   endtask

   task automatic wait_stage(input logic [N-1:0] v, input int budget, input string tag);
      int k = 0;
      while (rst_stage !== v && k < budget) begin
         tick();
         k++;
      end
      check_val(tag, 32'(rst_stage), 32'(v));
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      while (seq_done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check_val(tag, 32'(seq_done), 32'd1);
   endtask

   task automatic sw_pulse();
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
   endtask

   initial begin
      int t_hold, t_rise, t_drop, t_w, d, n;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      sw_rst_req = 1'b0;
      stage_ack  = '0;
      prev_stage = '1;
      m_phase = 0; m_rel = 0; m_err = 0; m_t0 = 0; m_trel = 0;
      lk1 = 0; lk2 = 0; ak1 = '0; ak2 = '0;
      repeat (3) tick();
      check_val("rst_stage_at_reset", 32'(rst_stage), 32'hF);
      check_val("state_at_reset", 32'(state), 32'(S_RESET));

      // Nominal release schedule with every gating ack present
      rst_n        = 1'b1;
      pll_locked   = 1'b1;
      stage_ack[2] = 1'b1;
      wait_state(S_HOLD, 20, "reach_hold");
      t_hold = cyc;
      chg_q.delete();
      wait_done(200, "nominal_done");
      check_val("nominal_rel_count", 32'(chg_q.size()), 32'(N));
      if (chg_q.size() == N) begin
         check_val("first_release_delay", 32'(chg_q[0] - t_hold), 32'(HC));
         for (int i = 1; i < N; i++)
            check_val("release_spacing", 32'(chg_q[i] - chg_q[i-1]), 32'(GAP));
         check_val("done_delay", 32'(cyc - chg_q[N-1]), 32'(GAP));
      end

      // Stage 3 waits on a late stage_ack[2]
      stage_ack[2] = 1'b0;
      sw_pulse();
      wait_stage(4'b1000, 200, "stage2_released");
      repeat (50) tick();
      check_val("ack_gate_hold", 32'(rst_stage), 32'h8);
      stage_ack[2] = 1'b1;
      t_rise = cyc;
      wait_stage(4'b0000, 20, "stage3_released");
      check_val("ack_to_release_edges", 32'(cyc - t_rise), 32'd3);
      wait_done(20, "ackgate_done");

      // Lock loss while idx=1
      sw_pulse();
      wait_stage(4'b1100, 200, "reach_idx1");
      pll_locked = 1'b0;
      t_drop = cyc;
      wait_stage(4'hF, 5, "lockloss_all_ones");
      check_val("lockloss_edges", 32'(cyc - t_drop), 32'd3);
      check_val("lockloss_state", 32'(state), 32'(S_RESET));
      tick();
      check_val("lockloss_wait", 32'(state), 32'(S_WAIT));
      pll_locked = 1'b1;
      wait_done(300, "lockloss_rerun_done");

      // Lock timeout, then lock arrives, then software clears the error
      pll_locked = 1'b0;
      sw_pulse();
      wait_state(S_WAIT, 3, "timeout_wait_entry");
      t_w = cyc;
      n = 0;
      while (lock_timeout_err !== 1'b1 && n < 150) begin
         tick();
         n++;
      end
      d = cyc - t_w;
      check_val("timeout_latency_ok", 32'(d >= LT - 1 && d <= LT + 1), 32'd1);
      repeat (10) tick();
      pll_locked = 1'b1;
      wait_done(300, "timeout_seq_done");
      check_val("timeout_err_sticky", 32'(lock_timeout_err), 32'd1);
      sw_pulse();
      check_val("timeout_err_cleared", 32'(lock_timeout_err), 32'd0);
      check_val("timeout_sw_all_ones", 32'(rst_stage), 32'hF);
      wait_done(300, "timeout_rerun_done");

      // Software request while DONE
      sw_pulse();
      check_val("sw_done_all_ones", 32'(rst_stage), 32'hF);
      check_val("sw_done_seq_done", 32'(seq_done), 32'd0);
      wait_done(300, "sw_rerun_done");

      // rst_n pulse during HOLD
      sw_pulse();
      wait_state(S_HOLD, 10, "rstn_reach_hold");
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("rstn_stage", 32'(rst_stage), 32'hF);
      check_val("rstn_done", 32'(seq_done), 32'd0);
      check_val("rstn_err", 32'(lock_timeout_err), 32'd0);
      check_val("rstn_state", 32'(state), 32'(S_RESET));
      wait_state(S_WAIT, 3, "rstn_wait_entry");
      n = 0;
      while (state === S_WAIT && n < 20) begin
         tick();
         n++;
      end
      check_val("rstn_wait_len", 32'(n), 32'd2);
      wait_done(300, "rstn_rerun_done");

      // Random lock drops, requests, resets and ack toggling
      for (int i = 0; i < 2500; i++) begin
         if (pll_locked) begin
            if ($urandom_range(0, 199) == 0) pll_locked = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            pll_locked = 1'b1;
         end
         sw_rst_req = ($urandom_range(0, 299) == 0);
         rst_n      = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 15) == 0) stage_ack[2] = ~stage_ack[2];
         tick();
      end
      rst_n      = 1'b1;
      sw_rst_req = 1'b0;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
